// File: rtl/pgm_sample_rom_port.sv
// pgm_sample_rom_port
//
// Responder for the ICS2115 wavetable engine's sample-read interface. A
// level-held read request is answered with a 64-bit word rotated so that the
// addressed byte sits in sdram_dout[7:0], followed by a one-cycle ready pulse.
// A single-line hit buffer holds the most recently fetched 64-bit word; misses
// go to the SDRAM arbiter's sample channel over a req/ack + valid handshake.
//
// Optional build macro: SAMPLE_PREFETCH_EN
//   When defined, a second (prefetch) buffer is filled with the next
//   sequential word after every miss response, and a hit on it is swapped
//   into the main buffer.
//
// Parameters
//   ADDR_W       byte-address width of requester and SDRAM
//   SAMPLE_BASE  byte offset of the sample ROM region, added to every address
//
// Ports
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   sdram_rd          read request, held until sdram_dout_ready
//   sdram_addr        byte address relative to SAMPLE_BASE
//   sdram_dout        lane-aligned read data, held after the ready pulse
//   sdram_dout_ready  one-cycle response strobe
//   sdram_busy        high whenever an access (or prefetch) is in progress
//   cache_inv         invalidate buffered data (ROM download in progress)
//   mem_req           backend fetch request, held until mem_ack
//   mem_addr          backend 64-bit word address
//   mem_ack           backend accepted the request
//   mem_valid         backend data strobe
//   mem_data          backend read word

module pgm_sample_rom_port #(
  parameter int                ADDR_W      = 29,
  parameter logic [ADDR_W-1:0] SAMPLE_BASE = 29'h0100_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdram_rd,
  input  logic [ADDR_W-1:0] sdram_addr,
  output logic [63:0]       sdram_dout,
  output logic              sdram_dout_ready,
  output logic              sdram_busy,
  input  logic              cache_inv,
  output logic              mem_req,
  output logic [ADDR_W-4:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [63:0]       mem_data
);

  localparam int TAG_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HIT     = 3'd1,
    MREQ    = 3'd2,
    MWAIT   = 3'd3,
    RESP    = 3'd4,
    PF_REQ  = 3'd5,
    PF_WAIT = 3'd6
  } state_t;

  state_t state, next_state;

  // Rotate right by whole bytes so byte 'lane' of the word lands in [7:0].
  function automatic logic [63:0] lane_rotate(input logic [63:0] w,
                                              input logic [2:0]  lane);
    logic [63:0] r;
    case (lane)
      3'd0:    r = w;
      3'd1:    r = {w[7:0],  w[63:8]};
      3'd2:    r = {w[15:0], w[63:16]};
      3'd3:    r = {w[23:0], w[63:24]};
      3'd4:    r = {w[31:0], w[63:32]};
      3'd5:    r = {w[39:0], w[63:40]};
      3'd6:    r = {w[47:0], w[63:48]};
      default: r = {w[55:0], w[63:56]};
    endcase
    return r;
  endfunction

  // Effective address wraps modulo 2^ADDR_W by construction of the adder width.
  logic [ADDR_W-1:0] ea;
  logic [TAG_W-1:0]  ea_tag;
  logic [2:0]        ea_lane;

  assign ea      = sdram_addr + SAMPLE_BASE;
  assign ea_tag  = ea[ADDR_W-1:3];
  assign ea_lane = ea[2:0];

  logic [63:0]      buf_data;
  logic [TAG_W-1:0] buf_tag;
  logic             buf_vld;
  logic [2:0]       req_lane;
  // Set when cache_inv is seen while a fetch is in flight, so the word it
  // returns is delivered but not marked valid.
  logic             inv_seen;

  logic accept;
  logic main_hit;
  logic mem_cap;

  assign accept   = (state == IDLE) && sdram_rd;
  // An invalidate in the accept cycle takes precedence over a tag match.
  assign main_hit = buf_vld && !cache_inv && (buf_tag == ea_tag);
  assign mem_cap  = ((state == MREQ) && mem_ack && mem_valid) ||
                    ((state == MWAIT) && mem_valid);

`ifdef SAMPLE_PREFETCH_EN
  logic [63:0]      pf_data;
  logic [TAG_W-1:0] pf_tag;
  logic             pf_vld;
  logic             pf_arm;
  logic             pf_hit;
  logic             pf_launch;
  logic             pf_cap;

  assign pf_hit    = pf_vld && !cache_inv && (pf_tag == ea_tag) && !main_hit;
  assign pf_launch = (state == IDLE) && !sdram_rd && pf_arm;
  assign pf_cap    = ((state == PF_REQ) && mem_ack && mem_valid) ||
                     ((state == PF_WAIT) && mem_valid);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sdram_rd) begin
`ifdef SAMPLE_PREFETCH_EN
          next_state = (main_hit || pf_hit) ? HIT : MREQ;
`else
          next_state = main_hit ? HIT : MREQ;
`endif
        end
`ifdef SAMPLE_PREFETCH_EN
        else if (pf_arm) begin
          next_state = PF_REQ;
        end
`endif
      end
      HIT:   next_state = IDLE;
      MREQ:  if (mem_ack) next_state = mem_valid ? RESP : MWAIT;
      MWAIT: if (mem_valid) next_state = RESP;
      RESP:  next_state = IDLE;
`ifdef SAMPLE_PREFETCH_EN
      PF_REQ:  if (mem_ack) next_state = mem_valid ? IDLE : PF_WAIT;
      PF_WAIT: if (mem_valid) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    sdram_dout_ready = (state == HIT) || (state == RESP);
    sdram_busy       = (state != IDLE);
    mem_req          = (state == MREQ) || (state == PF_REQ);
  end

  // Control and externally visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdram_dout <= '0;
      mem_addr   <= '0;
      buf_vld    <= 1'b0;
      inv_seen   <= 1'b0;
`ifdef SAMPLE_PREFETCH_EN
      pf_vld     <= 1'b0;
      pf_arm     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        mem_addr <= ea_tag;
        if (main_hit) sdram_dout <= lane_rotate(buf_data, ea_lane);
      end
      if (mem_cap) sdram_dout <= lane_rotate(mem_data, req_lane);

      if (mem_cap)        buf_vld <= !(inv_seen || cache_inv);
      else if (cache_inv) buf_vld <= 1'b0;

      if (state == IDLE)  inv_seen <= 1'b0;
      else if (cache_inv) inv_seen <= 1'b1;

`ifdef SAMPLE_PREFETCH_EN
      // pf_hit implies cache_inv is low, so the swap cannot lose an invalidate.
      if (accept && pf_hit) begin
        sdram_dout <= lane_rotate(pf_data, ea_lane);
        buf_vld    <= 1'b1;
      end

      if (accept && pf_hit) pf_vld <= buf_vld;
      else if (pf_cap)      pf_vld <= !(inv_seen || cache_inv);
      else if (cache_inv)   pf_vld <= 1'b0;

      // mem_addr still holds the tag of the miss just served.
      if (pf_launch) mem_addr <= mem_addr + 1'b1;

      if (state == RESP)              pf_arm <= 1'b1;
      else if (accept || pf_launch)   pf_arm <= 1'b0;
`endif
    end
  end

  // Buffer data and request lane: no reset, qualified by the valid bits
  always_ff @(posedge clk) begin
    if (accept) req_lane <= ea_lane;
    if (mem_cap) begin
      buf_data <= mem_data;
      buf_tag  <= mem_addr;
    end
`ifdef SAMPLE_PREFETCH_EN
    if (accept && pf_hit) begin
      buf_data <= pf_data;
      buf_tag  <= pf_tag;
      pf_data  <= buf_data;
      pf_tag   <= buf_tag;
    end
    if (pf_cap) begin
      pf_data <= mem_data;
      pf_tag  <= mem_addr;
    end
`endif
  end

endmodule
